// File: rtl/bas_pkg.sv
// ============================================================================
// Module  : bas_pkg
// Brief   : Shared types and constants for the BAS sequencer family.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bas_pkg;

    localparam int BF16_W = 16;

    localparam logic [BF16_W-1:0] POS_ZERO = 16'h0000;
    localparam logic [BF16_W-1:0] NEG_ZERO = 16'h8000;

    // An all-zero LFSR seed never leaves zero, so it is replaced by this value.
    localparam logic [8:0] SEED_ZERO_SUB = 9'h001;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_RUN     = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_OUTPUT  = 3'd4,
        ST_ERR     = 3'd5
    } seq_state_t;

    function automatic logic [8:0] seed_guard(input logic [8:0] s);
        return (s == 9'd0) ? SEED_ZERO_SUB : s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bas_sequencer_if.sv
// ============================================================================
// Module  : bas_sequencer_if
// Brief   : Command, BAS-core and result signals of the BAS sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface bas_sequencer_if;
    import bas_pkg::*;

    logic              start;
    logic [8:0]        cfg_count;
    logic [8:0]        cfg_seed1;
    logic [8:0]        cfg_seed2;
    logic [BF16_W-1:0] cfg_xi;
    logic [BF16_W-1:0] cfg_yi;
    logic [BF16_W-1:0] cfg_p;
    logic [BF16_W-1:0] cfg_e;

    logic              bas_reset;
    logic [8:0]        bas_count;
    logic [8:0]        bas_seed1;
    logic [8:0]        bas_seed2;
    logic [BF16_W-1:0] bas_xi;
    logic [BF16_W-1:0] bas_yi;
    logic [BF16_W-1:0] bas_P;
    logic [BF16_W-1:0] bas_E;
    logic [BF16_W-1:0] bas_xo;
    logic [BF16_W-1:0] bas_yo;
    logic [BF16_W-1:0] bas_fo;
    logic [31:0]       bas_clk_cnt;
    logic              bas_done;

    logic              res_valid;
    logic              res_ready;
    logic [BF16_W-1:0] res_x;
    logic [BF16_W-1:0] res_y;
    logic [BF16_W-1:0] res_f;
    logic [3:0]        res_run;
    logic [31:0]       res_cycles;
    logic              busy;
    logic              timeout_err;

    modport master (
        input  start, cfg_count, cfg_seed1, cfg_seed2, cfg_xi, cfg_yi, cfg_p, cfg_e,
        input  bas_xo, bas_yo, bas_fo, bas_clk_cnt, bas_done, res_ready,
        output bas_reset, bas_count, bas_seed1, bas_seed2, bas_xi, bas_yi, bas_P, bas_E,
        output res_valid, res_x, res_y, res_f, res_run, res_cycles, busy, timeout_err
    );

    modport slave (
        output start, cfg_count, cfg_seed1, cfg_seed2, cfg_xi, cfg_yi, cfg_p, cfg_e,
        output bas_xo, bas_yo, bas_fo, bas_clk_cnt, bas_done, res_ready,
        input  bas_reset, bas_count, bas_seed1, bas_seed2, bas_xi, bas_yi, bas_P, bas_E,
        input  res_valid, res_x, res_y, res_f, res_run, res_cycles, busy, timeout_err
    );

endinterface

`default_nettype wire

// File: rtl/bf16_less_than.sv
// ============================================================================
// Module  : bf16_less_than
// Brief   : Combinational BFloat16 a < b with +0 == -0; NaN not handled.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bf16_less_than
    import bas_pkg::*;
(
    input  wire logic [BF16_W-1:0] i_a,
    input  wire logic [BF16_W-1:0] i_b,
    output logic                   o_lt
);

    logic w_a_zero;
    logic w_b_zero;
    logic w_a_neg;
    logic w_b_neg;

    assign w_a_zero = (i_a == POS_ZERO) || (i_a == NEG_ZERO);
    assign w_b_zero = (i_b == POS_ZERO) || (i_b == NEG_ZERO);
    assign w_a_neg  = i_a[BF16_W-1];
    assign w_b_neg  = i_b[BF16_W-1];

    // Sign-magnitude ordering: larger magnitude is smaller when negative.
    always_comb begin
        o_lt = 1'b0;
        if (w_a_zero && w_b_zero) begin
            o_lt = 1'b0;
        end else if (w_a_neg != w_b_neg) begin
            o_lt = w_a_neg;
        end else if (!w_a_neg) begin
            o_lt = (i_a[BF16_W-2:0] < i_b[BF16_W-2:0]);
        end else begin
            o_lt = (i_a[BF16_W-2:0] > i_b[BF16_W-2:0]);
        end
    end

endmodule

`default_nettype wire

// File: rtl/bas_sequencer.sv
// ============================================================================
// Module  : bas_sequencer
// Brief   : Runs N_RUNS seeded BAS searches and reports the best result.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bas_sequencer
    import bas_pkg::*;
#(
    parameter int         N_RUNS    = 4,
    parameter logic [8:0] SEED_STEP = 9'd37,
    parameter int         TIMEOUT   = 1024
) (
    input  wire logic       clk,
    input  wire logic       reset,
    bas_sequencer_if.master bus
);

    localparam int TMO_W = $clog2(TIMEOUT);

    seq_state_t        r_state;
    logic [3:0]        r_k;
    logic [TMO_W-1:0]  r_tmo_cnt;
    logic [8:0]        r_base1;
    logic [8:0]        r_base2;
    logic [8:0]        r_off;

    logic              r_bas_reset;
    logic [8:0]        r_bas_count;
    logic [8:0]        r_bas_seed1;
    logic [8:0]        r_bas_seed2;
    logic [BF16_W-1:0] r_bas_xi;
    logic [BF16_W-1:0] r_bas_yi;
    logic [BF16_W-1:0] r_bas_p;
    logic [BF16_W-1:0] r_bas_e;

    logic              r_res_valid;
    logic [BF16_W-1:0] r_res_x;
    logic [BF16_W-1:0] r_res_y;
    logic [BF16_W-1:0] r_res_f;
    logic [3:0]        r_res_run;
    logic [31:0]       r_res_cycles;
    logic              r_busy;
    logic              r_timeout_err;

    logic              w_lt;
    logic              w_last;
    logic [8:0]        w_off_next;
    logic [32:0]       w_cyc_sum;

    bf16_less_than u_lt (
        .i_a  (bus.bas_fo),
        .i_b  (r_res_f),
        .o_lt (w_lt)
    );

    assign w_last     = (r_k == 4'(N_RUNS - 1));
    assign w_off_next = r_off + SEED_STEP;
    assign w_cyc_sum  = {1'b0, r_res_cycles} + {1'b0, bus.bas_clk_cnt};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_k           <= 4'd0;
            r_tmo_cnt     <= '0;
            r_base1       <= 9'd0;
            r_base2       <= 9'd0;
            r_off         <= 9'd0;
            r_bas_reset   <= 1'b1;
            r_bas_count   <= 9'd0;
            r_bas_seed1   <= 9'd0;
            r_bas_seed2   <= 9'd0;
            r_bas_xi      <= '0;
            r_bas_yi      <= '0;
            r_bas_p       <= '0;
            r_bas_e       <= '0;
            r_res_valid   <= 1'b0;
            r_res_x       <= '0;
            r_res_y       <= '0;
            r_res_f       <= '0;
            r_res_run     <= 4'd0;
            r_res_cycles  <= 32'd0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_bas_count   <= bus.cfg_count;
                        r_bas_xi      <= bus.cfg_xi;
                        r_bas_yi      <= bus.cfg_yi;
                        r_bas_p       <= bus.cfg_p;
                        r_bas_e       <= bus.cfg_e;
                        r_base1       <= bus.cfg_seed1;
                        r_base2       <= bus.cfg_seed2;
                        r_off         <= 9'd0;
                        r_bas_seed1   <= seed_guard(bus.cfg_seed1);
                        r_bas_seed2   <= seed_guard(bus.cfg_seed2);
                        r_res_x       <= '0;
                        r_res_y       <= '0;
                        r_res_f       <= '0;
                        r_res_run     <= 4'd0;
                        r_res_cycles  <= 32'd0;
                        r_timeout_err <= 1'b0;
                        r_k           <= 4'd0;
                        r_busy        <= 1'b1;
                        r_bas_reset   <= 1'b1;
                        r_state       <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    r_bas_reset <= 1'b0;
                    r_tmo_cnt   <= '0;
                    r_state     <= ST_RUN;
                end

                ST_RUN: begin
                    if (bus.bas_done) begin
                        r_state <= ST_CAPTURE;
                    end else if (r_tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                        r_timeout_err <= 1'b1;
                        r_bas_reset   <= 1'b1;
                        r_state       <= ST_ERR;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end

                ST_CAPTURE: begin
                    r_res_cycles <= w_cyc_sum[32] ? 32'hFFFF_FFFF : w_cyc_sum[31:0];
                    // Strict less-than keeps the earlier run on ties.
                    if ((r_k == 4'd0) || w_lt) begin
                        r_res_x   <= bus.bas_xo;
                        r_res_y   <= bus.bas_yo;
                        r_res_f   <= bus.bas_fo;
                        r_res_run <= r_k;
                    end
                    r_bas_reset <= 1'b1;
                    if (w_last) begin
                        r_res_valid <= 1'b1;
                        r_state     <= ST_OUTPUT;
                    end else begin
                        r_k         <= r_k + 4'd1;
                        r_off       <= w_off_next;
                        r_bas_seed1 <= seed_guard(r_base1 + w_off_next);
                        r_bas_seed2 <= seed_guard(r_base2 - w_off_next);
                        r_state     <= ST_LOAD;
                    end
                end

                ST_OUTPUT: begin
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end

                ST_ERR: begin
                    r_busy      <= 1'b0;
                    r_bas_reset <= 1'b1;
                    r_state     <= ST_IDLE;
                end

                default: begin
                    r_res_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_bas_reset <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.bas_reset   = r_bas_reset;
    assign bus.bas_count   = r_bas_count;
    assign bus.bas_seed1   = r_bas_seed1;
    assign bus.bas_seed2   = r_bas_seed2;
    assign bus.bas_xi      = r_bas_xi;
    assign bus.bas_yi      = r_bas_yi;
    assign bus.bas_P       = r_bas_p;
    assign bus.bas_E       = r_bas_e;
    assign bus.res_valid   = r_res_valid;
    assign bus.res_x       = r_res_x;
    assign bus.res_y       = r_res_y;
    assign bus.res_f       = r_res_f;
    assign bus.res_run     = r_res_run;
    assign bus.res_cycles  = r_res_cycles;
    assign bus.busy        = r_busy;
    assign bus.timeout_err = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_bas_sequencer.sv
// ============================================================================
// Module  : tb_bas_sequencer
// Brief   : Randomized self-checking bench for bas_sequencer with a BAS stub.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bas_sequencer;

    localparam int NR   = 4;
    localparam int STEP = 37;
    localparam int TMO  = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bas_sequencer_if bus();

    bas_sequencer #(.N_RUNS(NR), .SEED_STEP(9'd37), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.master)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // BAS core stub: answers each run from the tables after st_lat cycles.
    logic [15:0] st_xo [NR];
    logic [15:0] st_yo [NR];
    logic [15:0] st_fo [NR];
    logic [31:0] st_cc [NR];
    int          st_lat [NR];
    logic        st_hang = 1'b0;
    int          st_idx = 0;
    int          st_cyc = 0;

    always @(posedge clk) begin
        if (bus.start && !bus.busy) st_idx <= 0;
        if (bus.bas_reset) begin
            bus.bas_done <= 1'b0;
            st_cyc       <= 0;
        end else if (!bus.bas_done) begin
            st_cyc <= st_cyc + 1;
            if (!st_hang && st_cyc >= st_lat[st_idx % NR]) begin
                bus.bas_done    <= 1'b1;
                bus.bas_xo      <= st_xo[st_idx % NR];
                bus.bas_yo      <= st_yo[st_idx % NR];
                bus.bas_fo      <= st_fo[st_idx % NR];
                bus.bas_clk_cnt <= st_cc[st_idx % NR];
                st_idx          <= st_idx + 1;
            end
        end
    end

    // Map BF16 onto a signed integer line; +0 and -0 both land on 0.
    function automatic int bf_key(input logic [15:0] v);
        int m;
        m = int'({17'd0, v[14:0]});
        return v[15] ? -m : m;
    endfunction

    function automatic logic [8:0] exp_seed(input int base, input int k, input bit up);
        int s;
        s = up ? (base + k * STEP) % 512 : (base + 512 * NR - k * STEP) % 512;
        if (s == 0) s = 1;
        return 9'(s);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tables(input logic [15:0] f0, input logic [15:0] f1,
                              input logic [15:0] f2, input logic [15:0] f3,
                              input logic [31:0] cc, input int lat);
        st_fo[0] = f0; st_fo[1] = f1; st_fo[2] = f2; st_fo[3] = f3;
        for (int i = 0; i < NR; i++) begin
            st_xo[i]  = 16'($urandom);
            st_yo[i]  = 16'($urandom);
            st_cc[i]  = cc;
            st_lat[i] = lat;
        end
    endtask

    task automatic run_txn(input string nm, input logic [8:0] s1, input logic [8:0] s2,
                           input logic [8:0] cnt, input int hold, input bit poke);
        logic [15:0] xi, yi, p, e;
        int best, runs, hi_len;
        longint sum;
        logic prev_rst;
        bit got;
        xi = 16'($urandom); yi = 16'($urandom); p = 16'($urandom); e = 16'($urandom);
        bus.cfg_count = cnt; bus.cfg_seed1 = s1; bus.cfg_seed2 = s2;
        bus.cfg_xi = xi; bus.cfg_yi = yi; bus.cfg_p = p; bus.cfg_e = e;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk({nm, ".busy_start"}, 64'(bus.busy), 64'd1);
        chk({nm, ".tmo_clr"}, 64'(bus.timeout_err), 64'd0);
        bus.cfg_count = ~cnt; bus.cfg_seed1 = ~s1; bus.cfg_seed2 = ~s2;
        bus.cfg_xi = ~xi; bus.cfg_yi = ~yi; bus.cfg_p = ~p; bus.cfg_e = ~e;

        runs = 0; hi_len = 1; prev_rst = 1'b1; got = 1'b0;
        for (int cyc = 0; cyc < 4000 && !got; cyc++) begin
            if (bus.res_valid) begin
                got = 1'b1;
            end else begin
                if (prev_rst && !bus.bas_reset) begin
                    chk({nm, ".seed1"}, 64'(bus.bas_seed1), 64'(exp_seed(int'(s1), runs, 1'b1)));
                    chk({nm, ".seed2"}, 64'(bus.bas_seed2), 64'(exp_seed(int'(s2), runs, 1'b0)));
                    chk({nm, ".operands"}, {bus.bas_count, bus.bas_xi, bus.bas_yi, bus.bas_P},
                        {cnt, xi, yi, p});
                    if (runs > 0) chk({nm, ".load_len"}, 64'(hi_len), 64'd1);
                    runs++;
                end
                hi_len   = bus.bas_reset ? (prev_rst ? hi_len + 1 : 1) : 0;
                prev_rst = bus.bas_reset;
                bus.start = (poke && cyc == 3);
                tick();
            end
        end
        bus.start = 1'b0;
        chk({nm, ".got_valid"}, 64'(got), 64'd1);
        chk({nm, ".runs"}, 64'(runs), 64'(NR));

        best = 0; sum = 0;
        for (int k = 0; k < NR; k++) begin
            if (bf_key(st_fo[k]) < bf_key(st_fo[best])) best = k;
            sum += longint'(st_cc[k]);
        end
        if (sum > 64'h0FFFF_FFFF) sum = 64'h0FFFF_FFFF;

        chk({nm, ".res_f"}, 64'(bus.res_f), 64'(st_fo[best]));
        chk({nm, ".res_xy"}, {bus.res_x, bus.res_y}, {st_xo[best], st_yo[best]});
        chk({nm, ".res_run"}, 64'(bus.res_run), 64'(best));
        chk({nm, ".res_cycles"}, 64'(bus.res_cycles), 64'(sum));

        for (int i = 0; i < hold; i++) begin
            bus.res_ready = 1'b0;
            bus.start = (poke && i == 0);
            tick();
            bus.start = 1'b0;
            chk({nm, ".valid_hold"}, {63'd0, bus.res_valid}, 64'd1);
            chk({nm, ".f_hold"}, 64'(bus.res_f), 64'(st_fo[best]));
        end
        chk({nm, ".cfg_kept"}, {bus.bas_xi, bus.bas_E}, {xi, e});
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        chk({nm, ".valid_drop"}, 64'(bus.res_valid), 64'd0);
        chk({nm, ".busy_end"}, 64'(bus.busy), 64'd0);
    endtask

    task automatic run_timeout();
        int run_cyc;
        bit saw_valid, hit;
        st_hang = 1'b1;
        bus.cfg_count = 9'd5; bus.cfg_seed1 = 9'd3; bus.cfg_seed2 = 9'd9;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        run_cyc = 0; saw_valid = 1'b0; hit = 1'b0;
        for (int cyc = 0; cyc < 3000 && !hit; cyc++) begin
            if (bus.res_valid) saw_valid = 1'b1;
            if (bus.timeout_err) hit = 1'b1;
            else begin
                if (!bus.bas_reset) run_cyc++;
                tick();
            end
        end
        chk("tmo.flag", 64'(hit), 64'd1);
        chk("tmo.run_cycles", 64'(run_cyc), 64'(TMO));
        chk("tmo.err_busy", 64'(bus.busy), 64'd1);
        chk("tmo.err_bas_reset", 64'(bus.bas_reset), 64'd1);
        tick();
        chk("tmo.idle_busy", 64'(bus.busy), 64'd0);
        chk("tmo.sticky", 64'(bus.timeout_err), 64'd1);
        chk("tmo.no_valid", 64'(saw_valid | bus.res_valid), 64'd0);
        st_hang = 1'b0;
    endtask

    logic [15:0] pool [8];

    initial begin
        bus.start = 1'b0; bus.res_ready = 1'b0;
        bus.cfg_count = '0; bus.cfg_seed1 = '0; bus.cfg_seed2 = '0;
        bus.cfg_xi = '0; bus.cfg_yi = '0; bus.cfg_p = '0; bus.cfg_e = '0;
        set_tables(16'h0, 16'h0, 16'h0, 16'h0, 32'd0, 2);
        tick(); tick();
        chk("rst.bas_reset", 64'(bus.bas_reset), 64'd1);
        chk("rst.busy", 64'(bus.busy), 64'd0);
        chk("rst.valid", 64'(bus.res_valid), 64'd0);
        chk("rst.outputs", {bus.res_f, bus.res_cycles, bus.bas_seed1, bus.timeout_err},
            64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        set_tables(16'h4000, 16'h3F80, 16'hBF80, 16'h3F00, 32'd10, 6);
        run_txn("base", 9'h000, 9'd74, 9'd20, 3, 1'b0);
        chk("base.run_is_2", 64'(bus.res_run), 64'd2);

        set_tables(16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80, 32'd7, 3);
        run_txn("tie", 9'd100, 9'd200, 9'd8, 0, 1'b0);
        set_tables(16'h0000, 16'h8000, 16'h8000, 16'h0000, 32'd1, 1);
        run_txn("zeros", 9'd1, 9'd2, 9'd3, 1, 1'b0);
        set_tables(16'hC000, 16'hC100, 16'hBF80, 16'h0000, 32'hC000_0000, 2);
        run_txn("satur", 9'd511, 9'd37, 9'd4, 0, 1'b0);

        run_timeout();
        set_tables(16'h4100, 16'h3F00, 16'h4000, 16'h3F00, 32'd12, 4);
        run_txn("after_tmo", 9'd5, 9'd6, 9'd7, 0, 1'b0);

        // Asynchronous reset pulse in the middle of a run.
        set_tables(16'h4000, 16'h4000, 16'h4000, 16'h4000, 32'd3, 20);
        bus.cfg_count = 9'd9; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst.bas_reset", 64'(bus.bas_reset), 64'd1);
        chk("arst.busy", 64'(bus.busy), 64'd0);
        chk("arst.valid", 64'(bus.res_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        set_tables(16'hBE00, 16'h3E00, 16'hBF00, 16'h4000, 32'd5, 5);
        run_txn("post_arst", 9'd40, 9'd41, 9'd10, 1, 1'b0);

        set_tables(16'h4000, 16'hC000, 16'h3F80, 16'hC000, 32'd0, 0);
        run_txn("count0", 9'd11, 9'd22, 9'd0, 2, 1'b1);

        pool[0] = 16'h0000; pool[1] = 16'h8000; pool[2] = 16'h3F80; pool[3] = 16'hBF80;
        pool[4] = 16'h4000; pool[5] = 16'hC000; pool[6] = 16'h7F7F; pool[7] = 16'hFF7F;
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < NR; i++) begin
                st_fo[i]  = ($urandom_range(0, 2) == 0) ? 16'($urandom) & 16'hFF7F
                                                         : pool[$urandom_range(0, 7)];
                st_xo[i]  = 16'($urandom);
                st_yo[i]  = 16'($urandom);
                st_cc[i]  = ($urandom_range(0, 5) == 0) ? 32'($urandom) : 32'($urandom_range(0, 5000));
                st_lat[i] = int'($urandom_range(0, 12));
            end
            run_txn($sformatf("rnd%0d", t), 9'($urandom), 9'($urandom), 9'($urandom),
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
